// File: rtl/m_div_ctrl.sv
// Sequencing controller between EX and a shared unsigned multi-cycle divider.
// Resolves RV32M special cases and quotient/remainder reuse without the unit.
module m_div_ctrl #(
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            err_o,
  output logic            unit_ce_o,
  output logic [XLEN-1:0] unit_rs1_o,
  output logic [XLEN-1:0] unit_rs2_o,
  input  logic [XLEN-1:0] unit_quot_i,
  input  logic [XLEN-1:0] unit_rem_i,
  input  logic            unit_ready_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;

  logic            op_signed, op_rem;
  logic [XLEN-1:0] op_rs1, op_rs2;

  logic            c_vld, c_signed;
  logic [XLEN-1:0] c_rs1, c_rs2, c_quot, c_rem;

  logic            in_signed, in_rem, accept;
  logic            cache_hit, fast_hit, fast_err;
  logic [XLEN-1:0] fast_result, wait_result;
  logic            ready_take, time_up;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign in_signed = ~funct3_i[0];
  assign in_rem    = funct3_i[1];
  assign accept    = (state == S_IDLE) && valid_i && !flush_i;

  assign cache_hit = CACHE_EN && c_vld && (rs1_i == c_rs1) && (rs2_i == c_rs2) &&
                     (in_signed == c_signed);

  // Single-cycle outcomes, in priority order; fast_hit bypasses the unit.
  always_comb begin
    fast_hit    = 1'b1;
    fast_err    = 1'b0;
    fast_result = '0;
    if (!funct3_i[2]) begin
      fast_err = 1'b1;
    end else if (rs2_i == '0) begin
      fast_result = in_rem ? rs1_i : '1;
    end else if (in_signed && (rs1_i == INT_MIN) && (rs2_i == '1)) begin
      fast_result = in_rem ? '0 : INT_MIN;
    end else if (cache_hit) begin
      fast_result = in_rem ? neg_if(c_rem, in_signed && rs1_i[XLEN-1])
                           : neg_if(c_quot, in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]));
    end else begin
      fast_hit = 1'b0;
    end
  end

  // The unit reports ready while disabled, so the first WAIT cycle (cnt==0) is ignored.
  assign ready_take = (state == S_WAIT) && !flush_i && unit_ready_i && (cnt != '0);
  assign time_up    = (state == S_WAIT) && !flush_i && !ready_take &&
                      (cnt == CW'(TIMEOUT - 1));

  assign wait_result = op_rem ? neg_if(unit_rem_i, op_signed && op_rs1[XLEN-1])
                              : neg_if(unit_quot_i, op_signed && (op_rs1[XLEN-1] ^ op_rs2[XLEN-1]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = fast_hit ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (flush_i)                    state_nxt = S_IDLE;
        else if (ready_take || time_up) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = accept || (state == S_WAIT);
    done_o  = (state == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o   <= '0;
      err_o      <= 1'b0;
      unit_ce_o  <= 1'b0;
      unit_rs1_o <= '0;
      unit_rs2_o <= '0;
      cnt        <= '0;
      op_signed  <= 1'b0;
      op_rem     <= 1'b0;
      op_rs1     <= '0;
      op_rs2     <= '0;
      c_vld      <= 1'b0;
      c_signed   <= 1'b0;
      c_rs1      <= '0;
      c_rs2      <= '0;
      c_quot     <= '0;
      c_rem      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (fast_hit) begin
              result_o <= fast_result;
              err_o    <= fast_err;
            end else begin
              op_signed  <= in_signed;
              op_rem     <= in_rem;
              op_rs1     <= rs1_i;
              op_rs2     <= rs2_i;
              unit_rs1_o <= neg_if(rs1_i, in_signed && rs1_i[XLEN-1]);
              unit_rs2_o <= neg_if(rs2_i, in_signed && rs2_i[XLEN-1]);
              unit_ce_o  <= 1'b1;
              cnt        <= '0;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            unit_ce_o <= 1'b0;
          end else if (ready_take) begin
            unit_ce_o <= 1'b0;
            result_o  <= wait_result;
            err_o     <= 1'b0;
            if (CACHE_EN) begin
              c_vld    <= 1'b1;
              c_signed <= op_signed;
              c_rs1    <= op_rs1;
              c_rs2    <= op_rs2;
              c_quot   <= unit_quot_i;
              c_rem    <= unit_rem_i;
            end
          end else if (time_up) begin
            unit_ce_o <= 1'b0;
            result_o  <= '0;
            err_o     <= 1'b1;
            c_vld     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  err_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_div_ctrl.sv
// Self-checking bench for m_div_ctrl: directed cases plus randomized ops
// against an arithmetic reference model with its own reuse-cache bookkeeping.
module tb_m_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic        flush_i;
  logic        stall_o, done_o, err_o, unit_ce_o;
  logic [31:0] result_o, unit_rs1_o, unit_rs2_o;
  logic [31:0] unit_quot_i, unit_rem_i;
  logic        unit_ready_i;

  int n_vec = 0;
  int n_err = 0;

  bit          m_vld = 1'b0;
  bit          m_sgn;
  logic [31:0] m_a, m_b;

  m_div_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .stall_o(stall_o),
    .done_o(done_o), .result_o(result_o), .err_o(err_o), .unit_ce_o(unit_ce_o),
    .unit_rs1_o(unit_rs1_o), .unit_rs2_o(unit_rs2_o), .unit_quot_i(unit_quot_i),
    .unit_rem_i(unit_rem_i), .unit_ready_i(unit_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural RV32M semantics straight from the ISA rules.
  task automatic ref_result(input logic [2:0] f, input logic [31:0] a, b,
                            output logic err, output logic [31:0] res);
    int sa, sb;
    sa = a;
    sb = b;
    err = 1'b0;
    if (!f[2]) begin
      err = 1'b1;
      res = '0;
    end else if (b == 0) begin
      res = f[1] ? a : 32'hFFFF_FFFF;
    end else if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = f[1] ? 32'h0 : a;
      else res = f[1] ? 32'(sa % sb) : 32'(sa / sb);
    end else begin
      res = f[1] ? a % b : a / b;
    end
  endtask

  // One op: valid at cycle 0, unit_ready_i high from cycle ready_at on; every cycle is checked.
  task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, b, input int ready_at);
    logic        exp_err;
    logic [31:0] exp_res, ma, mb;
    bit          sgn, fast, tmo;
    int          first_ok, d;
    sgn = !f[0];
    ref_result(f, a, b, exp_err, exp_res);
    fast = !f[2] || b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (m_vld && m_a == a && m_b == b && m_sgn == sgn);
    first_ok = (ready_at < 2) ? 2 : ready_at;
    tmo = !fast && first_ok > 64;
    d = fast ? 1 : (tmo ? 65 : first_ok + 1);
    if (tmo) begin
      exp_err = 1'b1;
      exp_res = '0;
    end
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    @(negedge clk_i);
    valid_i = 1'b1;
    funct3_i = f;
    rs1_i = a;
    rs2_i = b;
    unit_quot_i = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
    unit_rem_i  = (mb == 0) ? ma : ma % mb;
    unit_ready_i = (ready_at <= 0);
    for (int c = 0; c <= d; c++) begin
      if (c > 0) begin
        @(posedge clk_i);
        @(negedge clk_i);
        unit_ready_i = (c >= ready_at);
      end
      #1;
      check_output($sformatf("stall c%0d", c), 32'(stall_o), 32'(c < d));
      check_output($sformatf("done c%0d", c), 32'(done_o), 32'(c == d));
      check_output($sformatf("ce c%0d", c), 32'(unit_ce_o), 32'(!fast && c >= 1 && c < d));
      if (c == 1 && !fast) begin
        check_output("unit_rs1", unit_rs1_o, ma);
        check_output("unit_rs2", unit_rs2_o, mb);
      end
      if (c == d) begin
        check_output($sformatf("result f%0d %h/%h", f, a, b), result_o, exp_res);
        check_output("err", 32'(err_o), 32'(exp_err));
      end
    end
    valid_i = 1'b0;
    unit_ready_i = 1'b0;
    if (!fast) begin
      if (tmo) m_vld = 1'b0;
      else begin
        m_vld = 1'b1;
        m_a = a;
        m_b = b;
        m_sgn = sgn;
      end
    end
  endtask

  initial begin
    logic [31:0] pa, pb, ra, rb;
    logic [2:0]  rf;
    int          mode;
    rst_i = 1'b1;
    valid_i = 1'b0;
    funct3_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    flush_i = 1'b0;
    unit_quot_i = '0;
    unit_rem_i = '0;
    unit_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check_output("reset done", 32'(done_o), 0);
    check_output("reset ce", 32'(unit_ce_o), 0);
    check_output("reset result", result_o, 0);
    check_output("reset err", 32'(err_o), 0);
    check_output("reset stall", 32'(stall_o), 0);
    rst_i = 1'b0;

    $display("[TB] directed: DIV/REM reuse, specials, latency, timeout");
    apply_stimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 4);
    apply_stimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 99);
    apply_stimulus(3'b111, 32'hFFFF_FFF9, 32'd2, 3);
    apply_stimulus(3'b101, 32'd5, 32'd0, 0);
    apply_stimulus(3'b110, 32'd5, 32'd0, 0);
    apply_stimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    apply_stimulus(3'b010, 32'd9, 32'd3, 0);
    apply_stimulus(3'b101, 32'd1000, 32'd7, 0);
    apply_stimulus(3'b100, 32'd77, 32'hFFFF_FFF5, 1000);
    apply_stimulus(3'b101, 32'd1000, 32'd7, 2);
    apply_stimulus(3'b100, 32'd77, 32'hFFFF_FFF5, 64);
    apply_stimulus(3'b110, 32'd77, 32'hFFFF_FFF5, 99);

    $display("[TB] directed: flush in second WAIT cycle");
    @(negedge clk_i);
    valid_i = 1'b1;
    funct3_i = 3'b100;
    rs1_i = 32'd100;
    rs2_i = 32'd9;
    unit_quot_i = 32'd11;
    unit_rem_i = 32'd1;
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    unit_ready_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    unit_ready_i = 1'b0;
    #1;
    check_output("flush done", 32'(done_o), 0);
    check_output("flush ce", 32'(unit_ce_o), 0);
    check_output("flush stall", 32'(stall_o), 0);
    @(negedge clk_i);
    #1;
    check_output("flush done later", 32'(done_o), 0);
    apply_stimulus(3'b100, 32'd77, 32'hFFFF_FFF5, 99);
    apply_stimulus(3'b100, 32'd100, 32'd9, 3);

    $display("[TB] directed: reset mid-WAIT");
    @(negedge clk_i);
    valid_i = 1'b1;
    funct3_i = 3'b101;
    rs1_i = 32'd1234;
    rs2_i = 32'd3;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    valid_i = 1'b0;
    #1;
    check_output("rst ce", 32'(unit_ce_o), 0);
    check_output("rst done", 32'(done_o), 0);
    check_output("rst result", result_o, 0);
    check_output("rst err", 32'(err_o), 0);
    check_output("rst unit_rs1", unit_rs1_o, 0);
    check_output("rst unit_rs2", unit_rs2_o, 0);
    check_output("rst stall", 32'(stall_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_vld = 1'b0;
    apply_stimulus(3'b100, 32'd100, 32'd9, 2);

    $display("[TB] random ops");
    pa = 32'd50;
    pb = 32'd7;
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 7);
      rf = 3'b100 | 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (mode)
        0: rb = 32'd0;
        1, 2: begin
          ra = pa;
          rb = pb;
        end
        3: begin
          ra = 32'($urandom_range(0, 200)) - 32'd100;
          rb = 32'($urandom_range(1, 20)) - 32'd10;
        end
        4: rf = 3'($urandom_range(0, 3));
        default: ;
      endcase
      apply_stimulus(rf, ra, rb, $urandom_range(0, 6));
      pa = ra;
      pb = rb;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
